byte_stream_rx: RTL and testbench

- Receive end of the 8-bit data/valid byte stream that submodule producers drive.
- Packs consecutive bytes into BYTES_PER_WORD-wide words, little-endian, and buffers them in a small FIFO.
- Presents the words downstream on a valid/ready handshake.
- The upstream stream has no backpressure, so the block flags sticky overflow when its buffer cannot absorb a word.

---
 rtl/byte_stream_rx.sv | 190 +++++++++++++++++++
 tb/tb_byte_stream_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_stream_rx.sv
// Byte-stream receiver: packs 8-bit bytes little-endian into words and queues them in a
// first-word-fall-through FIFO. Define BYTE_STREAM_RX_TIMEOUT_EN to flush idle partial words.
module byte_stream_rx #(
    parameter int BYTES_PER_WORD = 4,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data_in,
    input  logic                          valid,
    output logic [8*BYTES_PER_WORD-1:0]   word_out,
    output logic [BYTES_PER_WORD-1:0]     word_keep,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(DEPTH):0]        fill_level,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          pack_state_o
);

    localparam int W  = 8 * BYTES_PER_WORD;
    localparam int CW = $clog2(BYTES_PER_WORD);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("byte_stream_rx: illegal parameter combination");
    end

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_BUSY = 1'b1
    } fill_state_e;

    fill_state_e     state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    lanes_q, lanes_d;
    logic [W-1:0]    lanes_ins;
    logic            push_req;
    logic [W-1:0]    push_word;

    logic [W-1:0]    fifo_mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [LW-1:0]   fill_q;
    logic            fifo_full;
    logic            pop;
    logic            push_ok;
    logic            ovf_set;
    logic            overflow_q;

`ifdef BYTE_STREAM_RX_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0]          idle_q, idle_d;
    logic                   flush;
    logic [BYTES_PER_WORD-1:0] push_keep;
    logic [BYTES_PER_WORD-1:0] keep_mem_q [DEPTH];
`endif

    assign pack_state_o = (state_q == FILL_BUSY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL_IDLE;
            count_q <= '0;
            lanes_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lanes_q <= lanes_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        lanes_d   = lanes_q;
        push_req  = 1'b0;
        push_word = '0;
        lanes_ins = lanes_q;
`ifdef BYTE_STREAM_RX_TIMEOUT_EN
        push_keep = '0;
        idle_d    = idle_q;
        flush     = (state_q == FILL_BUSY) && (idle_q == IW'(TIMEOUT));
`endif
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (count_q == CW'(i)) lanes_ins[8*i +: 8] = data_in;
        end
`ifdef BYTE_STREAM_RX_TIMEOUT_EN
        // A flush empties the packer; a byte arriving on the same edge opens a fresh word.
        if (flush) begin
            push_req  = 1'b1;
            push_word = lanes_q;
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                push_keep[i] = (i < int'(count_q));
            end
            lanes_d = '0;
            count_d = '0;
            state_d = FILL_IDLE;
            if (valid) begin
                lanes_d[7:0] = data_in;
                count_d      = CW'(1);
                state_d      = FILL_BUSY;
            end
        end else
`endif
        if (valid) begin
            if (count_q == CW'(BYTES_PER_WORD - 1)) begin
                push_req  = 1'b1;
                push_word = lanes_ins;
                lanes_d   = '0;
                count_d   = '0;
                state_d   = FILL_IDLE;
`ifdef BYTE_STREAM_RX_TIMEOUT_EN
                push_keep = '1;
`endif
            end else begin
                lanes_d = lanes_ins;
                count_d = count_q + CW'(1);
                state_d = FILL_BUSY;
            end
        end
`ifdef BYTE_STREAM_RX_TIMEOUT_EN
        if (valid || flush) begin
            idle_d = '0;
        end else if (state_q == FILL_BUSY) begin
            idle_d = idle_q + IW'(1);
        end else begin
            idle_d = '0;
        end
`endif
    end

`ifdef BYTE_STREAM_RX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`endif

    // Handshake: a word moves downstream on any edge where word_valid && word_ready;
    // the head word and keep are held steady while word_valid=1 and word_ready=0.
    assign word_valid = (fill_q != '0);
    assign fifo_full  = (fill_q == LW'(DEPTH));
    assign pop        = word_valid && word_ready;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_q] <= push_word;
`ifdef BYTE_STREAM_RX_TIMEOUT_EN
            keep_mem_q[wr_q] <= push_keep;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop)     rd_q <= rd_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   fill_q <= fill_q + LW'(1);
                2'b01:   fill_q <= fill_q - LW'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)            overflow_q <= 1'b0;
        else if (ovf_set)      overflow_q <= 1'b1;
        else if (overflow_clr) overflow_q <= 1'b0;
    end

    assign overflow   = overflow_q;
    assign fill_level = fill_q;
    assign word_out   = word_valid ? fifo_mem_q[rd_q] : '0;
`ifdef BYTE_STREAM_RX_TIMEOUT_EN
    assign word_keep  = word_valid ? keep_mem_q[rd_q] : '0;
`else
    assign word_keep  = {BYTES_PER_WORD{word_valid}};
`endif

endmodule

// File: tb/tb_byte_stream_rx.sv
// Bench for byte_stream_rx: directed plan steps plus random traffic against a queue-based
// reference model; honours BYTE_STREAM_RX_TIMEOUT_EN when defined.
module tb_byte_stream_rx;

    localparam int BPW     = 4;
    localparam int W       = 8 * BPW;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     data_in = 8'h00;
    logic           valid = 1'b0;
    logic [W-1:0]   word_out;
    logic [BPW-1:0] word_keep;
    logic           word_valid;
    logic           word_ready = 1'b0;
    logic [2:0]     fill_level;
    logic           overflow;
    logic           overflow_clr = 1'b0;
    logic           pack_state_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0]     m_bytes[$];
    logic [W-1:0]   exp_q[$];
    logic [BPW-1:0] exp_kq[$];
    bit             m_ovf = 1'b0;
    int             m_idle = 0;

    byte_stream_rx #(.BYTES_PER_WORD(BPW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .valid        (valid),
        .word_out     (word_out),
        .word_keep    (word_keep),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .pack_state_o (pack_state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        int n;
        n = exp_q.size();
        check("valid", 64'(word_valid), 64'(n > 0));
        check("head",  64'(word_out),   (n > 0) ? 64'(exp_q[0])  : 64'd0);
        check("keep",  64'(word_keep),  (n > 0) ? 64'(exp_kq[0]) : 64'd0);
        check("fill",  64'(fill_level), 64'(n));
        check("ovf",   64'(overflow),   64'(m_ovf));
        check("busy",  64'(pack_state_o), 64'(m_bytes.size() > 0));
    endtask

    task automatic model_cycle(input bit v, input logic [7:0] d, input bit r, input bit clr);
        bit             push;
        bit             flush;
        logic [W-1:0]   w;
        logic [BPW-1:0] k;
        push  = 1'b0;
        flush = 1'b0;
        w     = '0;
        k     = '0;
        if (exp_q.size() > 0 && r) begin
            exp_q.delete(0);
            exp_kq.delete(0);
        end
`ifdef BYTE_STREAM_RX_TIMEOUT_EN
        flush = (m_bytes.size() > 0) && (m_idle == TIMEOUT);
        if (flush) begin
            for (int i = 0; i < m_bytes.size(); i++) begin
                w[8*i +: 8] = m_bytes[i];
                k[i] = 1'b1;
            end
            m_bytes.delete();
            push = 1'b1;
        end
`endif
        if (v) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == BPW) begin
                for (int i = 0; i < BPW; i++) w[8*i +: 8] = m_bytes[i];
                k = '1;
                m_bytes.delete();
                push = 1'b1;
            end
        end
`ifdef BYTE_STREAM_RX_TIMEOUT_EN
        if (v || flush)              m_idle = 0;
        else if (m_bytes.size() > 0) m_idle = m_idle + 1;
        else                         m_idle = 0;
`endif
        if (push && exp_q.size() >= DEPTH) begin
            m_ovf = 1'b1;
        end else begin
            if (push) begin
                exp_q.push_back(w);
                exp_kq.push_back(k);
            end
            if (clr) m_ovf = 1'b0;
        end
    endtask

    // Called just after a falling edge: check, drive, advance model and clock.
    task automatic step(input bit v, input logic [7:0] d, input bit r, input bit clr);
        compare_all();
        valid        = v;
        data_in      = d;
        word_ready   = r;
        overflow_clr = clr;
        model_cycle(v, d, r, clr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        word_ready = 1'b0;
        overflow_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_bytes.delete();
        exp_q.delete();
        exp_kq.delete();
        m_ovf  = 1'b0;
        m_idle = 0;
        check("rst_valid", 64'(word_valid), 64'd0);
        check("rst_fill",  64'(fill_level), 64'd0);
        check("rst_ovf",   64'(overflow),   64'd0);
        check("rst_word",  64'(word_out),   64'd0);
        check("rst_keep",  64'(word_keep),  64'd0);
        check("rst_busy",  64'(pack_state_o), 64'd0);
    endtask

    task automatic expect_head(input string tag, input logic [W-1:0] w, input logic [BPW-1:0] k);
        check({tag, "_valid"}, 64'(word_valid), 64'd1);
        check({tag, "_word"},  64'(word_out),   64'(w));
        check({tag, "_keep"},  64'(word_keep),  64'(k));
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // back-to-back word, single-cycle valid with ready held high
        step(1, 8'h11, 1, 0);
        step(1, 8'h22, 1, 0);
        step(1, 8'h33, 1, 0);
        step(1, 8'h44, 1, 0);
        expect_head("t1", 32'h44332211, 4'hF);
        step(0, 8'h00, 1, 0);
        check("t1_one_cycle", 64'(word_valid), 64'd0);

        // same word with 3-cycle gaps
        for (int b = 0; b < 4; b++) begin
            step(1, 8'(8'h11 * (b + 1)), 1, 0);
            if (b < 3) begin
                for (int g = 0; g < 3; g++) step(0, 8'h00, 1, 0);
                check("t2_no_early", 64'(word_valid), 64'd0);
            end
        end
        expect_head("t2", 32'h44332211, 4'hF);
        step(0, 8'h00, 1, 0);

        // five words into a stalled FIFO: fifth dropped, overflow set
        for (int b = 0; b < 20; b++) step(1, 8'((b / 4) * 4 + (b % 4) + ((b / 4) * 12 > 0 ? 0 : 0)), 0, 0);
        check("t3_fill", 64'(fill_level), 64'd4);
        check("t3_ovf",  64'(overflow),   64'd1);
        expect_head("t3_w0", 32'h03020100, 4'hF);
        step(0, 8'h00, 1, 0);
        expect_head("t3_w1", 32'h07060504, 4'hF);
        step(0, 8'h00, 1, 0);
        expect_head("t3_w2", 32'h0B0A0908, 4'hF);
        step(0, 8'h00, 1, 0);
        expect_head("t3_w3", 32'h0F0E0D0C, 4'hF);
        step(0, 8'h00, 1, 0);
        check("t3_empty", 64'(word_valid), 64'd0);
        check("t3_ovf_sticky", 64'(overflow), 64'd1);
        step(0, 8'h00, 0, 1);
        check("t3_ovf_clr", 64'(overflow), 64'd0);

        // full FIFO: completing byte coincides with a pop
        for (int b = 0; b < 16; b++) step(1, 8'(8'h20 + b), 0, 0);
        step(1, 8'h30, 0, 0);
        step(1, 8'h31, 0, 0);
        step(1, 8'h32, 0, 0);
        check("t4_full", 64'(fill_level), 64'd4);
        step(1, 8'h33, 1, 0);
        check("t4_fill", 64'(fill_level), 64'd4);
        check("t4_ovf",  64'(overflow),   64'd0);
        expect_head("t4_w0", 32'h27262524, 4'hF);
        step(0, 8'h00, 1, 0);
        expect_head("t4_w1", 32'h2B2A2928, 4'hF);
        step(0, 8'h00, 1, 0);
        expect_head("t4_w2", 32'h2F2E2D2C, 4'hF);
        step(0, 8'h00, 1, 0);
        expect_head("t4_w3", 32'h33323130, 4'hF);
        step(0, 8'h00, 1, 0);
        check("t4_empty", 64'(word_valid), 64'd0);

        // reset in the middle of a word discards the partial bytes
        step(1, 8'hAA, 1, 0);
        step(1, 8'hBB, 1, 0);
        compare_all();
        do_reset();
        step(1, 8'h01, 1, 0);
        step(1, 8'h02, 1, 0);
        step(1, 8'h03, 1, 0);
        step(1, 8'h04, 1, 0);
        expect_head("t5", 32'h04030201, 4'hF);
        step(0, 8'h00, 1, 0);
        check("t5_only_one", 64'(word_valid), 64'd0);

        // random traffic: heavy stall phase, then mostly-ready phase
        for (int c = 0; c < 700; c++) begin
            bit v, r, clr;
            v   = ($urandom_range(0, 9) < 7);
            r   = (c < 350) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            step(v, 8'($urandom_range(0, 255)), r, clr);
        end
        for (int c = 0; c < 8; c++) step(0, 8'h00, 1, 1);

        // partial word left idle
        do_reset();
        step(1, 8'hAA, 0, 0);
        step(1, 8'hBB, 0, 0);
        for (int c = 0; c < TIMEOUT + 4; c++) step(0, 8'h00, 0, 0);
`ifdef BYTE_STREAM_RX_TIMEOUT_EN
        expect_head("t6_flush", 32'h0000BBAA, 4'h3);
        check("t6_fill", 64'(fill_level), 64'd1);
`else
        check("t6_no_word", 64'(word_valid), 64'd0);
        check("t6_still_busy", 64'(pack_state_o), 64'd1);
`endif
        step(0, 8'h00, 1, 0);
        compare_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
